// File: rtl/uart_depacketizer.sv
`default_nettype none
// ============================================================================
// Module   : uart_depacketizer
// Function : 8N1 UART receiver with mid-bit sampling, show-ahead receive FIFO
//            and AXI-Stream master output; framing/overflow error pulses.
// Revision : 1.0  initial release
// ============================================================================
module uart_depacketizer #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  rx_busy,
  output logic                  frame_error,
  output logic                  overflow,
  output logic                  fifo_full,
  output logic                  fifo_empty
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W        = $clog2(DATA_WIDTH + 1);
  localparam int ADDR_W       = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------- input sync
  logic [1:0] sync;
  logic [1:0] sync_fill;
  logic       line_prev;
  logic       line;
  logic       fall;

  // sync_fill marks when the synchronizer holds real line samples, so the
  // forced-high reset value can never be mistaken for an idle-to-start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      sync_fill <= 2'b00;
      line_prev <= 1'b0;
    end else begin
      sync      <= {sync[0], serial_in};
      sync_fill <= {sync_fill[0], 1'b1};
      line_prev <= sync_fill[1] & sync[1];
    end
  end

  assign line = sync[1];
  assign fall = line_prev & ~line;

  // ---------------------------------------------------------------- receiver
  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [BIT_W-1:0]      bit_idx, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  wr_req;
  logic                  ferr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    wr_req    = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_nxt   = '0;
          state_nxt = line ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nxt   = '0;
          shreg_nxt = DATA_WIDTH'({line, shreg} >> 1);
          if (bit_idx == LAST_BIT) state_nxt = STOP;
          else                     bit_nxt   = bit_idx + BIT_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // Sampling mid-stop-bit leaves half a bit to catch a back-to-back start.
        if (cnt == BIT_END) begin
          state_nxt = IDLE;
          wr_req    = line;
          ferr_nxt  = ~line;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W:0]       count;
  logic                  rd;
  logic                  wr_ok;
  logic                  ferr_q, ovf_q;

  assign rd    = m_axis_tvalid & m_axis_tready;
  assign wr_ok = wr_req & (~fifo_full | rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_nxt;
      ovf_q  <= wr_req & ~wr_ok;
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd)    rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_ok, rd})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= shreg;
  end

  assign fifo_full     = (count == FULL_CNT);
  assign fifo_empty    = (count == '0);
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr];
  assign rx_busy       = (state != IDLE);
  assign frame_error   = ferr_q;
  assign overflow      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_depacketizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_depacketizer
// Function : scoreboard bench for uart_depacketizer (16 clk per bit).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_depacketizer;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       rx_busy, frame_error, overflow, fifo_full, fifo_empty;

  uart_depacketizer #(
    .BAUD_RATE (BAUD),
    .CLK_FREQ  (CLK_FREQ),
    .FIFO_DEPTH(DEPTH),
    .DATA_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .rx_busy      (rx_busy),
    .frame_error  (frame_error),
    .overflow     (overflow),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         beat_cnt = 0;
  int         ferr_cnt = 0;
  int         ovf_cnt = 0;
  logic       lat_en = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cnt++;
        if (exp_q.size() == 0)
          check("extra_beat", {24'h0, m_axis_tdata}, 32'hFFFF_FFFF);
        else
          check("beat_data", {24'h0, m_axis_tdata}, {24'h0, exp_q.pop_front()});
      end
      if (frame_error) ferr_cnt++;
      if (overflow)    ovf_cnt++;
      if (lat_en && prev_busy && !rx_busy)
        check("tvalid_latency", {31'h0, m_axis_tvalid}, 32'h1);
      prev_busy = rx_busy;
    end
  end

  task automatic send_bit(input logic v);
    serial_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 m_axis_tready = v;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'h0);
  endtask

  task automatic check_reset_vals();
    check("rst_tdata",  {24'h0, m_axis_tdata},  32'h0);
    check("rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("rst_busy",   {31'h0, rx_busy},       32'h0);
    check("rst_ferr",   {31'h0, frame_error},   32'h0);
    check("rst_ovf",    {31'h0, overflow},      32'h0);
    check("rst_full",   {31'h0, fifo_full},     32'h0);
    check("rst_empty",  {31'h0, fifo_empty},    32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, f0, o0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    repeat (CPB) @(negedge clk);

    // single frame with latency check
    b0 = beat_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
    lat_en = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    send_bit(1'b1);
    lat_en = 1'b0;
    wait_drain();
    check("a5_beats", beat_cnt - b0, 1);
    check("a5_ferr",  ferr_cnt - f0, 0);
    check("a5_ovf",   ovf_cnt - o0, 0);

    // back-to-back frames, no idle gap
    b0 = beat_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_bit(1'b1);
    wait_drain();
    check("b2b_beats", beat_cnt - b0, 3);
    check("b2b_ferr",  ferr_cnt - f0, 0);

    // framing error then a good frame
    b0 = beat_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1);
    wait_drain();
    check("ferr_pulses", ferr_cnt - f0, 1);
    check("ferr_beats",  beat_cnt - b0, 1);

    // fill to full, then overflow on the 17th frame
    set_ready(1'b0);
    o0 = ovf_cnt;
    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      if (i == DEPTH - 2) check("not_full_15", {31'h0, fifo_full}, 32'h0);
      if (i == DEPTH - 1) check("full_16", {31'h0, fifo_full}, 32'h1);
    end
    send_bit(1'b1);
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("stall_head", {24'h0, m_axis_tdata}, 32'h0);
    b0 = beat_cnt;
    set_ready(1'b1);
    wait_drain();
    @(negedge clk);
    check("drain_beats", beat_cnt - b0, DEPTH);
    check("drain_empty", {31'h0, fifo_empty}, 32'h1);

    // short glitch on the line
    b0 = beat_cnt; f0 = ferr_cnt;
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", {31'h0, rx_busy}, 32'h1);
    repeat (CPB) @(negedge clk);
    check("glitch_idle", {31'h0, rx_busy}, 32'h0);
    check("glitch_beats", beat_cnt - b0, 0);
    check("glitch_ferr",  ferr_cnt - f0, 0);

    // reset in the middle of 0x7E, then 0x42
    b0 = beat_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    serial_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    send_bit(1'b1);
    send_bit(1'b1);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    send_bit(1'b1);
    wait_drain();
    check("rst_beats", beat_cnt - b0, 1);
    check("rst_ferr_cnt", ferr_cnt - f0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
